// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receiver and its consumer,
// plus the receiver's status flags.
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;
  logic [LW-1:0] fifo_level;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, fifo_level,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, fifo_level,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x oversampling 8N1 UART receiver with majority-vote bit decisions,
// feeding a first-word-fall-through byte FIFO.
module uart_rx_fifo #(
  parameter int unsigned PRESCALE   = 27,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic           RX,
  uart_rx_fifo_if.master bus
);
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  logic          r_rx_meta, r_rxs;
  logic [PW-1:0] r_presc;
  state_e        r_state;
  logic [3:0]    r_sc;
  logic [2:0]    r_idx;
  logic [1:0]    r_smp;
  logic [7:0]    r_data;
  logic          r_frame_err, r_overrun;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [LW-1:0] r_level;

  logic       w_tick, w_active, w_decide, w_wrap, w_vote;
  logic       w_valid, w_full, w_pop, w_good_stop, w_push;
  logic [3:0] w_sc_nxt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rxs     <= r_rx_meta;
    end
  end

  // Free-running tick; never realigned to the start edge.
  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // Actions are keyed on the sample count this tick advances to.
  assign w_active    = (r_state == StStart) || (r_state == StData) || (r_state == StStop);
  assign w_sc_nxt    = r_sc + 4'd1;
  assign w_decide    = w_tick && w_active && (w_sc_nxt == 4'd9);
  assign w_wrap      = w_tick && w_active && (w_sc_nxt == 4'd0);
  assign w_vote      = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxs) | (r_smp[1] & r_rxs);
  assign w_valid     = (r_level != '0);
  assign w_full      = (r_level == LW'(FIFO_DEPTH));
  assign w_pop       = w_valid && bus.rx_ready;
  assign w_good_stop = w_decide && (r_state == StStop) && w_vote;
  assign w_push      = w_good_stop && (!w_full || w_pop);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= StIdle;
      r_sc        <= '0;
      r_idx       <= '0;
      r_smp       <= '0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (w_tick) begin
        if (w_active) begin
          r_sc <= w_sc_nxt;
          if (w_sc_nxt == 4'd7) r_smp[0] <= r_rxs;
          if (w_sc_nxt == 4'd8) r_smp[1] <= r_rxs;
        end
        unique case (r_state)
          StIdle: begin
            if (!r_rxs) begin
              r_sc    <= '0;
              r_state <= StStart;
            end
          end
          StStart: begin
            if (w_decide && w_vote) begin
              r_state <= StIdle;
            end else if (w_wrap) begin
              r_idx   <= '0;
              r_state <= StData;
            end
          end
          StData: begin
            if (w_decide) r_data[r_idx] <= w_vote;
            if (w_wrap) begin
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= StStop;
            end
          end
          StStop: begin
            if (w_decide) begin
              if (w_vote) begin
                r_overrun <= !w_push;
                r_state   <= StIdle;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= StWaitHigh;
              end
            end
          end
          // A held-low line (break) must see a high sample before re-arming.
          StWaitHigh: begin
            if (r_rxs) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign bus.rx_data    = r_mem[r_rd_ptr];
  assign bus.rx_valid   = w_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames in, transaction-level FIFO model
// predicting occupancy, popped bytes and flag pulses cycle by cycle.
module tb_uart_rx_fifo;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BIT      = 16 * PRESCALE;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic RX      = 1'b1;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .PRESCALE  (PRESCALE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .RX     (RX),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycles since reset release; tick phase is cyc mod PRESCALE.
  int unsigned cyc;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Model state
  byte unsigned mq[$];
  int unsigned  pend_cyc[$];
  logic         pend_good[$];
  byte unsigned pend_byte[$];
  logic         exp_fe = 1'b0;
  logic         exp_ov = 1'b0;
  int unsigned  n_fe = 0, n_ov = 0, n_valid = 0, n_pop = 0;
  byte unsigned last_pop = 8'h00;

  initial begin
    logic         mpop, mpush;
    byte unsigned pbyte;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        mq.delete();
        pend_cyc.delete();
        pend_good.delete();
        pend_byte.delete();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
      end
      check("rx_valid", 32'(bus.rx_valid), 32'(mq.size() != 0));
      check("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
      check("frame_err", 32'(bus.frame_err), 32'(exp_fe));
      check("overrun", 32'(bus.overrun), 32'(exp_ov));
      if (bus.frame_err) n_fe++;
      if (bus.overrun)   n_ov++;
      if (bus.rx_valid)  n_valid++;
      mpop = HRESETn && (mq.size() != 0) && bus.rx_ready;
      if (mpop) begin
        check("rx_data", 32'(bus.rx_data), 32'(mq[0]));
        n_pop++;
        last_pop = bus.rx_data;
      end
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      mpush  = 1'b0;
      pbyte  = 8'h00;
      if (HRESETn && (pend_cyc.size() != 0) && (cyc == pend_cyc[0])) begin
        if (!pend_good[0])                          exp_fe = 1'b1;
        else if (mq.size() == int'(DEPTH) && !mpop) exp_ov = 1'b1;
        else begin
          mpush = 1'b1;
          pbyte = pend_byte[0];
        end
        void'(pend_cyc.pop_front());
        void'(pend_good.pop_front());
        void'(pend_byte.pop_front());
      end
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back(pbyte);
    end
  end

  task automatic tick_cycles(input int unsigned n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    tick_cycles(BIT);
  endtask

  // Start edge driven in cycle r reaches the synchroniser output at r+2; it is
  // detected on the next tick and the stop decision falls 153 ticks later.
  function automatic int unsigned push_cycle(input int unsigned r);
    int unsigned d = r + 2;
    while ((d % PRESCALE) != PRESCALE - 1) d++;
    return d + 153 * PRESCALE;
  endfunction

  task automatic send_byte(input byte unsigned b, input logic stop);
    pend_cyc.push_back(push_cycle(cyc));
    pend_good.push_back(stop);
    pend_byte.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
    check({tag, "_data"}, 32'(bus.rx_data), 32'h00);
    check({tag, "_fe"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_ov"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned  v0, f0, o0, p0, pc;
    byte unsigned fb[5];
    byte unsigned c;
    logic         done;

    bus.rx_ready = 1'b0;
    tick_cycles(3);
    check_reset_outputs("rst");
    HRESETn = 1'b1;
    tick_cycles(2 * BIT);

    // Single byte, consumer always ready
    bus.rx_ready = 1'b1;
    v0 = n_valid; f0 = n_fe; o0 = n_ov; p0 = n_pop;
    send_byte(8'hA5, 1'b1);
    tick_cycles(BIT);
    check("single_valid_cycles", n_valid - v0, 32'd1);
    check("single_pops", n_pop - p0, 32'd1);
    check("single_last", 32'(last_pop), 32'hA5);
    check("single_flags", (n_fe - f0) + (n_ov - o0), 32'd0);

    // Five back-to-back bytes into a depth-4 FIFO with no consumer
    bus.rx_ready = 1'b0;
    o0 = n_ov; p0 = n_pop;
    for (int i = 1; i <= 5; i++) send_byte(byte'(i), 1'b1);
    tick_cycles(BIT);
    check("fill_level", 32'(bus.fifo_level), 32'd4);
    check("fill_overruns", n_ov - o0, 32'd1);
    bus.rx_ready = 1'b1;
    tick_cycles(8);
    check("drain_pops", n_pop - p0, 32'd4);
    check("drain_last", 32'(last_pop), 32'h04);
    check("drain_level", 32'(bus.fifo_level), 32'd0);

    // Sub-half-bit glitch is a false start
    v0 = n_valid; f0 = n_fe; o0 = n_ov;
    RX = 1'b0;
    tick_cycles(16);
    RX = 1'b1;
    tick_cycles(2 * BIT);
    check("glitch_valid", n_valid - v0, 32'd0);
    check("glitch_flags", (n_fe - f0) + (n_ov - o0), 32'd0);

    // Bad stop bit, then a long break: one frame_err only
    f0 = n_fe; p0 = n_pop;
    send_byte(8'h3C, 1'b0);
    tick_cycles(20 * BIT);
    check("break_frame_errs", n_fe - f0, 32'd1);
    check("break_level", 32'(bus.fifo_level), 32'd0);
    RX = 1'b1;
    tick_cycles(2 * BIT);
    send_byte(8'h7E, 1'b1);
    tick_cycles(BIT);
    check("after_break_pops", n_pop - p0, 32'd1);
    check("after_break_byte", 32'(last_pop), 32'h7E);

    // Full FIFO: pop in the same cycle as the fifth push
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) fb[i] = byte'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b1);
    o0 = n_ov; p0 = n_pop;
    pc = push_cycle(cyc);
    fork
      send_byte(fb[4], 1'b1);
      begin
        while (cyc < pc) tick_cycles(1);
        bus.rx_ready = 1'b1;
        tick_cycles(1);
        bus.rx_ready = 1'b0;
      end
    join
    tick_cycles(BIT);
    check("samecyc_overrun", n_ov - o0, 32'd0);
    check("samecyc_level", 32'(bus.fifo_level), 32'd4);
    check("samecyc_pops", n_pop - p0, 32'd1);
    check("samecyc_head", 32'(bus.rx_data), 32'(fb[1]));
    bus.rx_ready = 1'b1;
    tick_cycles(8);
    check("samecyc_tail", 32'(last_pop), 32'(fb[4]));

    // Reset during data bit 4 with one byte already queued
    bus.rx_ready = 1'b0;
    send_byte(byte'($urandom_range(0, 255)), 1'b1);
    tick_cycles(BIT);
    check("prereset_level", 32'(bus.fifo_level), 32'd1);
    c = byte'($urandom_range(0, 255));
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c[i]);
    RX = c[4];
    tick_cycles(20);
    f0 = n_fe; o0 = n_ov;
    HRESETn = 1'b0;
    RX      = 1'b1;
    tick_cycles(1);
    check_reset_outputs("midrst");
    tick_cycles(4);
    HRESETn = 1'b1;
    tick_cycles(2 * BIT);
    check("postreset_flags", (n_fe - f0) + (n_ov - o0), 32'd0);
    bus.rx_ready = 1'b1;
    p0 = n_pop;
    send_byte(8'h55, 1'b1);
    tick_cycles(BIT);
    check("postreset_pops", n_pop - p0, 32'd1);
    check("postreset_byte", 32'(last_pop), 32'h55);

    // Random bytes, gaps and a sluggish consumer
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          tick_cycles($urandom_range(0, 40));
          send_byte(byte'($urandom_range(0, 255)), 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.rx_ready = ($urandom_range(0, 3) == 0);
          tick_cycles(1);
        end
      end
    join
    bus.rx_ready = 1'b1;
    tick_cycles(BIT);
    check("random_drained", 32'(bus.fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
